iboot_memif_arbiter: RTL and testbench

Sits directly downstream of the iboot ROM loader and upstream of the SDRAM memory interface. During boot it passes the loader's word-write requests into a small request FIFO toward memory, and holds the CPU off. Once the loader deasserts its valid flag and the FIFO drains, ownership passes permanently to the CPU request port, which then uses the same FIFO path. It also returns memory read data to the CPU and counts boot words written.

---
 rtl/iboot_memif_arbiter_if.sv | 55 +++++
 rtl/iboot_memif_arbiter.sv | 140 ++++++++++++++
 tb/tb_iboot_memif_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iboot_memif_arbiter_if.sv
// Request/response bundle between the iboot loader, the CPU request port,
// the SDRAM memory interface and the boot arbiter that sits between them.
interface iboot_memif_arbiter_if;
    // loader request port
    logic        iIBOOT_VALID;
    logic        iIBOOT_REQ_VALID;
    logic [3:0]  iIBOOT_REQ_DQM;
    logic        iIBOOT_REQ_RW;
    logic [24:0] iIBOOT_REQ_ADDR;
    logic [31:0] iIBOOT_REQ_DATA;
    logic        oIBOOT_REQ_LOCK;
    // CPU request port and read return
    logic        iCPU_REQ_VALID;
    logic [3:0]  iCPU_REQ_DQM;
    logic        iCPU_REQ_RW;
    logic [24:0] iCPU_REQ_ADDR;
    logic [31:0] iCPU_REQ_DATA;
    logic        oCPU_REQ_LOCK;
    logic        oCPU_RD_VALID;
    logic [31:0] oCPU_RD_DATA;
    // memory interface side
    logic        oMEM_REQ_VALID;
    logic [3:0]  oMEM_REQ_DQM;
    logic        oMEM_REQ_RW;
    logic [24:0] oMEM_REQ_ADDR;
    logic [31:0] oMEM_REQ_DATA;
    logic        iMEM_REQ_LOCK;
    logic        iMEM_RD_VALID;
    logic [31:0] iMEM_RD_DATA;
    // boot status
    logic        oBOOT_DONE;
    logic [21:0] oBOOT_WORDS;

    // arbiter side
    modport slave (
        input  iIBOOT_VALID, iIBOOT_REQ_VALID, iIBOOT_REQ_DQM, iIBOOT_REQ_RW,
               iIBOOT_REQ_ADDR, iIBOOT_REQ_DATA,
               iCPU_REQ_VALID, iCPU_REQ_DQM, iCPU_REQ_RW, iCPU_REQ_ADDR, iCPU_REQ_DATA,
               iMEM_REQ_LOCK, iMEM_RD_VALID, iMEM_RD_DATA,
        output oIBOOT_REQ_LOCK, oCPU_REQ_LOCK, oCPU_RD_VALID, oCPU_RD_DATA,
               oMEM_REQ_VALID, oMEM_REQ_DQM, oMEM_REQ_RW, oMEM_REQ_ADDR, oMEM_REQ_DATA,
               oBOOT_DONE, oBOOT_WORDS
    );

    // environment side (loader, CPU and memory models)
    modport master (
        output iIBOOT_VALID, iIBOOT_REQ_VALID, iIBOOT_REQ_DQM, iIBOOT_REQ_RW,
               iIBOOT_REQ_ADDR, iIBOOT_REQ_DATA,
               iCPU_REQ_VALID, iCPU_REQ_DQM, iCPU_REQ_RW, iCPU_REQ_ADDR, iCPU_REQ_DATA,
               iMEM_REQ_LOCK, iMEM_RD_VALID, iMEM_RD_DATA,
        input  oIBOOT_REQ_LOCK, oCPU_REQ_LOCK, oCPU_RD_VALID, oCPU_RD_DATA,
               oMEM_REQ_VALID, oMEM_REQ_DQM, oMEM_REQ_RW, oMEM_REQ_ADDR, oMEM_REQ_DATA,
               oBOOT_DONE, oBOOT_WORDS
    );
endinterface

// File: rtl/iboot_memif_arbiter.sv
// Boot-time memory arbiter: the iboot loader owns the request FIFO toward
// SDRAM until it finishes and the FIFO drains, after which the CPU owns it
// for good. Read returns are forwarded to the CPU only once it owns memory.
module iboot_memif_arbiter #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iRESET_SYNC,
    iboot_memif_arbiter_if.slave  bus
);

    localparam int                ENTRY_W  = 62;
    localparam logic [P_DEPTH_N:0] FULL_CNT = (P_DEPTH_N + 1)'(P_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [P_DEPTH_N:0]     count;
    logic [P_DEPTH_N-1:0]   wr_ptr;
    logic [P_DEPTH_N-1:0]   rd_ptr;
    logic [ENTRY_W-1:0]     fifo_mem [P_DEPTH];
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   boot_push;
    logic                   iboot_lock;
    logic                   cpu_lock;
    logic [21:0]            boot_words;
    logic                   rd_valid;
    logic [31:0]            rd_data;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Memory lock is the only thing that can stall a non-empty FIFO.
    assign pop   = !empty && !bus.iMEM_REQ_LOCK;

    // Ownership FSM: next state, source locks and push selection.
    always_comb begin
        state_next = state;
        iboot_lock = 1'b1;
        cpu_lock   = 1'b1;
        push       = 1'b0;
        boot_push  = 1'b0;
        push_entry = {bus.iIBOOT_REQ_DQM, bus.iIBOOT_REQ_RW,
                      bus.iIBOOT_REQ_ADDR, bus.iIBOOT_REQ_DATA};
        case (state)
            ST_BOOT: begin
                iboot_lock = full;
                push       = bus.iIBOOT_REQ_VALID && !full;
                boot_push  = push;
                if (!bus.iIBOOT_VALID) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (empty) state_next = ST_RUN;
            end
            ST_RUN: begin
                cpu_lock   = full;
                push       = bus.iCPU_REQ_VALID && !full;
                push_entry = {bus.iCPU_REQ_DQM, bus.iCPU_REQ_RW,
                              bus.iCPU_REQ_ADDR, bus.iCPU_REQ_DATA};
            end
            default: state_next = ST_BOOT;
        endcase
    end

    // Ownership state register; either reset restarts the boot phase.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)         state <= ST_BOOT;
        else if (iRESET_SYNC) state <= ST_BOOT;
        else                  state <= state_next;
    end

    // FIFO occupancy and pointers; a reset flushes whatever is queued.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (iRESET_SYNC) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge iCLOCK) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    // Boot word counter; only loader pushes advance it, wrapping naturally.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)         boot_words <= '0;
        else if (iRESET_SYNC) boot_words <= '0;
        else if (boot_push)   boot_words <= boot_words + 1'b1;
    end

    // Read return register; returns arriving before the CPU owns memory are dropped.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (iRESET_SYNC) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= bus.iMEM_RD_VALID && (state == ST_RUN);
            rd_data  <= bus.iMEM_RD_DATA;
        end
    end

    assign head               = fifo_mem[rd_ptr];
    assign bus.oMEM_REQ_VALID = pop;
    assign bus.oMEM_REQ_DQM   = head[61:58];
    assign bus.oMEM_REQ_RW    = head[57];
    assign bus.oMEM_REQ_ADDR  = head[56:32];
    assign bus.oMEM_REQ_DATA  = head[31:0];
    assign bus.oIBOOT_REQ_LOCK = iboot_lock;
    assign bus.oCPU_REQ_LOCK   = cpu_lock;
    assign bus.oCPU_RD_VALID   = rd_valid;
    assign bus.oCPU_RD_DATA    = rd_data;
    assign bus.oBOOT_DONE      = (state == ST_RUN);
    assign bus.oBOOT_WORDS     = boot_words;

endmodule

// File: tb/tb_iboot_memif_arbiter.sv
// Bench for iboot_memif_arbiter: a table of boot writes, hand sequences for
// backpressure/drain/read-return/reset corners, and randomized traffic, all
// compared every cycle against a queue-based reference model.
module tb_iboot_memif_arbiter;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic srst  = 1'b0;

    iboot_memif_arbiter_if bus ();

    iboot_memif_arbiter #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (srst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model: owner phase 0 = loader, 1 = draining, 2 = CPU
    logic [61:0] mq[$];
    int          phase;
    logic [21:0] mwords;
    logic        m_rdv;
    logic [31:0] m_rdd;

    typedef struct {
        logic        req_v;
        logic [24:0] addr;
        logic        mem_lock;
        logic        exp_mv;
        logic [24:0] exp_addr;
        logic        exp_ilock;
        logic        exp_clock;
        logic [21:0] exp_words;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction

    function automatic bit m_ilock();
        return (phase == 0) ? m_full() : 1'b1;
    endfunction

    function automatic bit m_clock();
        return (phase == 2) ? m_full() : 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        phase  = 0;
        mwords = '0;
        m_rdv  = 1'b0;
        m_rdd  = '0;
    endtask

    task automatic model_check();
        bit mv;
        mv = (mq.size() != 0) && !bus.iMEM_REQ_LOCK;
        chk("m.mem_valid", 64'(bus.oMEM_REQ_VALID), 64'(mv));
        if (mv)
            chk("m.mem_entry", 64'({bus.oMEM_REQ_DQM, bus.oMEM_REQ_RW,
                                     bus.oMEM_REQ_ADDR, bus.oMEM_REQ_DATA}), 64'(mq[0]));
        chk("m.iboot_lock", 64'(bus.oIBOOT_REQ_LOCK), 64'(m_ilock()));
        chk("m.cpu_lock",   64'(bus.oCPU_REQ_LOCK),   64'(m_clock()));
        chk("m.boot_done",  64'(bus.oBOOT_DONE),      64'(phase == 2));
        chk("m.boot_words", 64'(bus.oBOOT_WORDS),     64'(mwords));
        chk("m.rd_valid",   64'(bus.oCPU_RD_VALID),   64'(m_rdv));
        chk("m.rd_data",    64'(bus.oCPU_RD_DATA),    64'(m_rdd));
    endtask

    task automatic model_step();
        bit full, pop, push_l, push_c;
        int np;
        if (srst) begin
            model_reset();
        end else begin
            full   = m_full();
            pop    = (mq.size() != 0) && !bus.iMEM_REQ_LOCK;
            push_l = (phase == 0) && bus.iIBOOT_REQ_VALID && !full;
            push_c = (phase == 2) && bus.iCPU_REQ_VALID && !full;
            np = phase;
            if (phase == 0 && !bus.iIBOOT_VALID) np = 1;
            if (phase == 1 && mq.size() == 0)    np = 2;
            m_rdv = bus.iMEM_RD_VALID && (phase == 2);
            m_rdd = bus.iMEM_RD_DATA;
            if (pop) void'(mq.pop_front());
            if (push_l) begin
                mq.push_back({bus.iIBOOT_REQ_DQM, bus.iIBOOT_REQ_RW,
                              bus.iIBOOT_REQ_ADDR, bus.iIBOOT_REQ_DATA});
                mwords = mwords + 1'b1;
            end
            if (push_c)
                mq.push_back({bus.iCPU_REQ_DQM, bus.iCPU_REQ_RW,
                              bus.iCPU_REQ_ADDR, bus.iCPU_REQ_DATA});
            phase = np;
        end
    endtask

    // inputs are set just after a falling edge; settle samples 1 time unit later
    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic adv();
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic async_rst();
        rst_n = 1'b0;
        #1;
        model_reset();
        model_check();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic loader(input logic v, input logic [24:0] a, input logic [31:0] d);
        bus.iIBOOT_REQ_VALID = v;
        bus.iIBOOT_REQ_ADDR  = a;
        bus.iIBOOT_REQ_DATA  = d;
        bus.iIBOOT_REQ_DQM   = 4'hF;
        bus.iIBOOT_REQ_RW    = 1'b1;
    endtask

    task automatic randomize_run_inputs();
        bus.iMEM_REQ_LOCK  = ($urandom_range(0, 2) == 0);
        bus.iMEM_RD_VALID  = $urandom_range(0, 1);
        bus.iMEM_RD_DATA   = $urandom;
        bus.iCPU_REQ_VALID = $urandom_range(0, 1) && !m_clock();
        bus.iCPU_REQ_DQM   = 4'($urandom);
        bus.iCPU_REQ_RW    = 1'($urandom);
        bus.iCPU_REQ_ADDR  = 25'($urandom);
        bus.iCPU_REQ_DATA  = $urandom;
        bus.iIBOOT_REQ_VALID = $urandom_range(0, 1) && !m_ilock();
        bus.iIBOOT_REQ_DQM   = 4'($urandom);
        bus.iIBOOT_REQ_RW    = 1'($urandom);
        bus.iIBOOT_REQ_ADDR  = 25'($urandom);
        bus.iIBOOT_REQ_DATA  = $urandom;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // boot writes: one push per cycle, each popped the following cycle
        for (int i = 0; i < 10; i++) begin
            tbl[i].req_v     = (i < 8);
            tbl[i].addr      = (i < 8) ? 25'(i) : 25'd0;
            tbl[i].mem_lock  = 1'b0;
            tbl[i].exp_mv    = (i >= 1 && i <= 8);
            tbl[i].exp_addr  = (i >= 1) ? 25'(i - 1) : 25'd0;
            tbl[i].exp_ilock = 1'b0;
            tbl[i].exp_clock = 1'b1;
            tbl[i].exp_words = (i < 8) ? 22'(i) : 22'd8;
        end

        bus.iIBOOT_VALID = 1'b1;
        loader(1'b0, '0, '0);
        bus.iCPU_REQ_VALID = 1'b0; bus.iCPU_REQ_DQM = '0; bus.iCPU_REQ_RW = 1'b0;
        bus.iCPU_REQ_ADDR = '0; bus.iCPU_REQ_DATA = '0;
        bus.iMEM_REQ_LOCK = 1'b0; bus.iMEM_RD_VALID = 1'b0; bus.iMEM_RD_DATA = '0;
        model_reset();

        // reset state
        @(negedge clk);
        settle();
        chk("rst.mem_valid", 64'(bus.oMEM_REQ_VALID), 64'd0);
        chk("rst.iboot_lock", 64'(bus.oIBOOT_REQ_LOCK), 64'd0);
        chk("rst.cpu_lock", 64'(bus.oCPU_REQ_LOCK), 64'd1);
        chk("rst.done", 64'(bus.oBOOT_DONE), 64'd0);
        chk("rst.words", 64'(bus.oBOOT_WORDS), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: table-driven boot writes
        for (int i = 0; i < 10; i++) begin
            loader(tbl[i].req_v, tbl[i].addr, 32'hA000_0000 + 32'(tbl[i].addr));
            bus.iMEM_REQ_LOCK = tbl[i].mem_lock;
            settle();
            chk("t1.mem_valid", 64'(bus.oMEM_REQ_VALID), 64'(tbl[i].exp_mv));
            if (tbl[i].exp_mv) begin
                chk("t1.addr", 64'(bus.oMEM_REQ_ADDR), 64'(tbl[i].exp_addr));
                chk("t1.data", 64'(bus.oMEM_REQ_DATA), 64'(32'hA000_0000 + 32'(tbl[i].exp_addr)));
            end
            chk("t1.iboot_lock", 64'(bus.oIBOOT_REQ_LOCK), 64'(tbl[i].exp_ilock));
            chk("t1.cpu_lock", 64'(bus.oCPU_REQ_LOCK), 64'(tbl[i].exp_clock));
            chk("t1.words", 64'(bus.oBOOT_WORDS), 64'(tbl[i].exp_words));
            adv();
        end

        // 2: fill under memory backpressure, single release, refill
        bus.iMEM_REQ_LOCK = 1'b1;
        for (int k = 0; k < 4; k++) begin
            loader(1'b1, 25'(k), 32'hB000_0000 + 32'(k));
            cyc();
        end
        loader(1'b0, '0, '0);
        bus.iMEM_REQ_LOCK = 1'b0;
        bus.iMEM_RD_VALID = 1'b1; bus.iMEM_RD_DATA = 32'h1234_5678;
        settle();
        chk("t2.full_lock", 64'(bus.oIBOOT_REQ_LOCK), 64'd1);
        chk("t2.pop_valid", 64'(bus.oMEM_REQ_VALID), 64'd1);
        chk("t2.pop_addr", 64'(bus.oMEM_REQ_ADDR), 64'd0);
        adv();
        bus.iMEM_RD_VALID = 1'b0;
        bus.iMEM_REQ_LOCK = 1'b1;
        loader(1'b1, 25'd4, 32'hB000_0004);
        settle();
        chk("t2.lock_drop", 64'(bus.oIBOOT_REQ_LOCK), 64'd0);
        chk("t5.boot_rd_discard", 64'(bus.oCPU_RD_VALID), 64'd0);
        adv();
        loader(1'b0, '0, '0);
        bus.iMEM_REQ_LOCK = 1'b0;
        settle();
        chk("t2.refull_lock", 64'(bus.oIBOOT_REQ_LOCK), 64'd1);
        adv();
        loader(1'b1, 25'd5, 32'hB000_0005);
        settle();
        chk("t2.pushpop_addr", 64'(bus.oMEM_REQ_ADDR), 64'd2);
        adv();
        bus.iMEM_REQ_LOCK = 1'b1;
        loader(1'b1, 25'd6, 32'hB000_0006);
        settle();
        chk("t2.count_kept", 64'(bus.oIBOOT_REQ_LOCK), 64'd0);
        adv();
        loader(1'b0, '0, '0);
        settle();
        chk("t2.full_again", 64'(bus.oIBOOT_REQ_LOCK), 64'd1);
        adv();

        // 3: drain with 3 queued entries
        bus.iMEM_REQ_LOCK = 1'b0;
        settle();
        chk("t3.pre_pop", 64'(bus.oMEM_REQ_ADDR), 64'd3);
        adv();
        bus.iMEM_REQ_LOCK = 1'b1;
        bus.iIBOOT_VALID  = 1'b0;
        cyc();
        settle();
        chk("t3.drain_ilock", 64'(bus.oIBOOT_REQ_LOCK), 64'd1);
        chk("t3.drain_clock", 64'(bus.oCPU_REQ_LOCK), 64'd1);
        chk("t3.drain_done", 64'(bus.oBOOT_DONE), 64'd0);
        adv();
        bus.iMEM_REQ_LOCK = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3.drain_valid", 64'(bus.oMEM_REQ_VALID), 64'd1);
            chk("t3.drain_addr", 64'(bus.oMEM_REQ_ADDR), 64'(4 + k));
            adv();
        end
        settle();
        chk("t3.empty", 64'(bus.oMEM_REQ_VALID), 64'd0);
        chk("t3.done_not_yet", 64'(bus.oBOOT_DONE), 64'd0);
        adv();
        settle();
        chk("t3.done", 64'(bus.oBOOT_DONE), 64'd1);
        chk("t3.cpu_unlock", 64'(bus.oCPU_REQ_LOCK), 64'd0);
        chk("t3.words", 64'(bus.oBOOT_WORDS), 64'd15);
        adv();

        // 4: CPU read and 1-cycle read return
        bus.iCPU_REQ_VALID = 1'b1; bus.iCPU_REQ_ADDR = 25'h100;
        bus.iCPU_REQ_RW = 1'b0; bus.iCPU_REQ_DQM = 4'h0; bus.iCPU_REQ_DATA = '0;
        cyc();
        bus.iCPU_REQ_VALID = 1'b0;
        settle();
        chk("t4.mem_valid", 64'(bus.oMEM_REQ_VALID), 64'd1);
        chk("t4.mem_addr", 64'(bus.oMEM_REQ_ADDR), 64'h100);
        chk("t4.mem_rw", 64'(bus.oMEM_REQ_RW), 64'd0);
        adv();
        bus.iMEM_RD_VALID = 1'b1; bus.iMEM_RD_DATA = 32'hDEAD_BEEF;
        cyc();
        bus.iMEM_RD_VALID = 1'b0; bus.iMEM_RD_DATA = '0;
        settle();
        chk("t4.rd_valid", 64'(bus.oCPU_RD_VALID), 64'd1);
        chk("t4.rd_data", 64'(bus.oCPU_RD_DATA), 64'hDEAD_BEEF);
        adv();
        settle();
        chk("t4.rd_valid_gone", 64'(bus.oCPU_RD_VALID), 64'd0);
        adv();

        // randomized CPU traffic
        for (int n = 0; n < 400; n++) begin
            randomize_run_inputs();
            cyc();
        end

        // 6: synchronous reset with 2 entries queued
        bus.iCPU_REQ_VALID = 1'b0; bus.iIBOOT_REQ_VALID = 1'b0;
        bus.iMEM_REQ_LOCK = 1'b0; bus.iMEM_RD_VALID = 1'b0;
        for (int n = 0; n < 10 && mq.size() != 0; n++) cyc();
        chk("t6.drain_bound", 64'(mq.size()), 64'd0);
        bus.iMEM_REQ_LOCK = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.iCPU_REQ_VALID = 1'b1; bus.iCPU_REQ_ADDR = 25'(16'h200 + k);
            bus.iCPU_REQ_DATA = 32'hC0DE_0000 + 32'(k); bus.iCPU_REQ_RW = 1'b1;
            cyc();
        end
        bus.iCPU_REQ_VALID = 1'b0;
        bus.iIBOOT_VALID = 1'b1;
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        bus.iMEM_REQ_LOCK = 1'b0;
        settle();
        chk("t6.mem_valid", 64'(bus.oMEM_REQ_VALID), 64'd0);
        chk("t6.done", 64'(bus.oBOOT_DONE), 64'd0);
        chk("t6.words", 64'(bus.oBOOT_WORDS), 64'd0);
        chk("t6.cpu_lock", 64'(bus.oCPU_REQ_LOCK), 64'd1);
        adv();

        // randomized full boot episodes, one interrupted by an async reset
        for (int ep = 0; ep < 3; ep++) begin
            int drop_at;
            drop_at = $urandom_range(20, 150);
            bus.iIBOOT_VALID = 1'b1;
            for (int n = 0; n < 500; n++) begin
                if (n == drop_at) bus.iIBOOT_VALID = 1'b0;
                randomize_run_inputs();
                if (ep == 1 && n == 250) begin
                    async_rst();
                    bus.iIBOOT_VALID = 1'b1;
                    drop_at = 300;
                end else begin
                    cyc();
                end
            end
            bus.iIBOOT_REQ_VALID = 1'b0; bus.iCPU_REQ_VALID = 1'b0;
            srst = 1'b1;
            cyc();
            srst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
